uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter. Accepts one parallel word per valid/ready

---
 rtl/uart_tx_cfg.sv | 149 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: one word per valid/ready handshake, shifted out LSB first
// as start, data, optional parity, and 1 or 2 stop bits on a registered, idle-high line.
module uart_tx_cfg #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_MAX = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 out_q, out_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    // The line is registered, so each transition loads out_d with the value of the bit it enters.
    always_comb begin
        // NOTE: every target gets a default first so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        out_d   = out_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                out_d = 1'b1;
                if (tx_valid) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    out_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_MAX) begin
                        stop_d = 1'b0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            out_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            out_d   = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        out_d   = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    out_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_MAX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        out_d   = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign tx_out   = out_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_ready = (state_q == S_IDLE) && !sys_rst;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances (8E1, 8O1, 7N2) at 10 clocks per bit,
// one task per scenario with inline comparisons against hand-computed frames.
module tb_uart_tx_cfg;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] tx_data;
    logic [2:0] valid_v, ready_v, out_v, busy_v, done_v;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .tx_out(out_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8o1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .tx_out(out_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7n2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data[6:0]), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .tx_out(out_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    // Sends one word on instance d and records the line value at the start of each bit period,
    // plus any change inside a bit or any low level in the 20 idle cycles after the frame.
    task automatic send_frame(input int d, input logic [7:0] word, input int nbits,
                              input int chg_at, input logic [7:0] chg_val, input bit chg_pulse,
                              output logic [15:0] line, output int busy_cyc, output int done_at,
                              output int dones, output int glitches);
        logic cur;
        @(negedge sys_clk);
        tests_run++;
        if (ready_v[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_before_send dut%0d: got %b want 1", d, ready_v[d]);
        end
        tx_data    = word;
        valid_v[d] = 1'b1;
        @(posedge sys_clk);
        #1;
        valid_v[d] = 1'b0;
        line = '0; busy_cyc = 0; done_at = -1; dones = 0; glitches = 0; cur = 1'b0;
        for (int c = 0; c < nbits * 10 + 20; c++) begin
            @(negedge sys_clk);
            if (c < nbits * 10) begin
                if (c % 10 == 0) begin
                    cur          = out_v[d];
                    line[c / 10] = cur;
                end else if (out_v[d] !== cur) begin
                    glitches++;
                end
            end else if (out_v[d] !== 1'b1) begin
                glitches++;
            end
            if (busy_v[d] === 1'b1) busy_cyc++;
            if (done_v[d] === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            if (c == chg_at) begin
                tx_data = chg_val;
                if (chg_pulse) valid_v[d] = 1'b1;
            end
            if (c == chg_at + 1) valid_v[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        valid_v = '0;
        tx_data = '0;
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if (out_v !== 3'b111) begin tests_failed++; $display("FAIL reset_out: got %b want 111", out_v); end
        tests_run++;
        if (busy_v !== 3'b000) begin tests_failed++; $display("FAIL reset_busy: got %b want 000", busy_v); end
        tests_run++;
        if (done_v !== 3'b000) begin tests_failed++; $display("FAIL reset_done: got %b want 000", done_v); end
        tests_run++;
        if (ready_v !== 3'b000) begin tests_failed++; $display("FAIL reset_ready_in_reset: got %b want 000", ready_v); end
        sys_rst = 1'b0;
        #1;
        tests_run++;
        if (ready_v !== 3'b111) begin tests_failed++; $display("FAIL reset_ready_after: got %b want 111", ready_v); end
    endtask

    task automatic test_frame_8e1();
        logic [15:0] line;
        int busy_cyc, done_at, dones, glitches;
        send_frame(0, 8'hA5, 11, -1, 8'h00, 1'b0, line, busy_cyc, done_at, dones, glitches);
        tests_run++;
        if (line !== 16'({1'b1, 1'b0, 8'hA5, 1'b0})) begin tests_failed++; $display("FAIL 8e1_line: got %h want %h", line, 16'({1'b1, 1'b0, 8'hA5, 1'b0})); end
        tests_run++;
        if (glitches !== 0) begin tests_failed++; $display("FAIL 8e1_bit_hold: got %0d glitches want 0", glitches); end
        tests_run++;
        if (busy_cyc !== 110) begin tests_failed++; $display("FAIL 8e1_busy_cycles: got %0d want 110", busy_cyc); end
        tests_run++;
        if (dones !== 1) begin tests_failed++; $display("FAIL 8e1_done_count: got %0d want 1", dones); end
        tests_run++;
        if (done_at !== 110) begin tests_failed++; $display("FAIL 8e1_done_cycle: got %0d want 110", done_at); end
        tests_run++;
        if (ready_v[0] !== 1'b1) begin tests_failed++; $display("FAIL 8e1_ready_after: got %b want 1", ready_v[0]); end
    endtask

    task automatic test_odd_parity();
        logic [15:0] line;
        int busy_cyc, done_at, dones, glitches;
        send_frame(1, 8'h00, 11, -1, 8'h00, 1'b0, line, busy_cyc, done_at, dones, glitches);
        tests_run++;
        if (line !== 16'({1'b1, 1'b1, 8'h00, 1'b0})) begin tests_failed++; $display("FAIL odd_parity_00: got %h want %h", line, 16'({1'b1, 1'b1, 8'h00, 1'b0})); end
        send_frame(1, 8'h07, 11, -1, 8'h00, 1'b0, line, busy_cyc, done_at, dones, glitches);
        tests_run++;
        if (line !== 16'({1'b1, 1'b0, 8'h07, 1'b0})) begin tests_failed++; $display("FAIL odd_parity_07: got %h want %h", line, 16'({1'b1, 1'b0, 8'h07, 1'b0})); end
        tests_run++;
        if (dones !== 1 || glitches !== 0) begin tests_failed++; $display("FAIL odd_parity_frame: got dones=%0d glitches=%0d want 1/0", dones, glitches); end
    endtask

    task automatic test_7n2_data_change();
        logic [15:0] line;
        int busy_cyc, done_at, dones, glitches;
        send_frame(2, 8'h41, 10, 35, 8'h7F, 1'b0, line, busy_cyc, done_at, dones, glitches);
        tests_run++;
        if (line !== 16'({2'b11, 7'h41, 1'b0})) begin tests_failed++; $display("FAIL 7n2_line: got %h want %h", line, 16'({2'b11, 7'h41, 1'b0})); end
        tests_run++;
        if (busy_cyc !== 100) begin tests_failed++; $display("FAIL 7n2_busy_cycles: got %0d want 100", busy_cyc); end
        tests_run++;
        if (done_at !== 100 || dones !== 1) begin tests_failed++; $display("FAIL 7n2_done: got cycle=%0d count=%0d want 100/1", done_at, dones); end
        tests_run++;
        if (glitches !== 0) begin tests_failed++; $display("FAIL 7n2_bit_hold: got %0d glitches want 0", glitches); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] wave;
        logic [10:0]  f1, f2;
        int           dones, done1, done2;
        @(negedge sys_clk);
        tx_data    = 8'h01;
        valid_v[0] = 1'b1;
        @(posedge sys_clk);
        #1;
        tx_data = 8'hFF;
        wave = '0; dones = 0; done1 = -1; done2 = -1;
        for (int c = 0; c < 240; c++) begin
            @(negedge sys_clk);
            wave[c] = out_v[0];
            if (done_v[0] === 1'b1) begin
                dones++;
                if (done1 < 0) done1 = c; else if (done2 < 0) done2 = c;
            end
            if (c == 111) valid_v[0] = 1'b0;
        end
        for (int k = 0; k < 11; k++) begin
            f1[k] = wave[10 * k + 5];
            f2[k] = wave[111 + 10 * k + 5];
        end
        tests_run++;
        if (dones !== 2) begin tests_failed++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
        tests_run++;
        if (done1 !== 110 || done2 !== 221) begin tests_failed++; $display("FAIL b2b_done_cycles: got %0d/%0d want 110/221", done1, done2); end
        tests_run++;
        if (wave[110] !== 1'b1 || wave[111] !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap: got %b%b want 10", wave[110], wave[111]); end
        tests_run++;
        if (f1 !== {1'b1, 1'b1, 8'h01, 1'b0}) begin tests_failed++; $display("FAIL b2b_frame1: got %h want %h", f1, {1'b1, 1'b1, 8'h01, 1'b0}); end
        tests_run++;
        if (f2 !== {1'b1, 1'b0, 8'hFF, 1'b0}) begin tests_failed++; $display("FAIL b2b_frame2: got %h want %h", f2, {1'b1, 1'b0, 8'hFF, 1'b0}); end
    endtask

    task automatic test_ignore_busy();
        logic [15:0] line;
        int busy_cyc, done_at, dones, glitches;
        send_frame(0, 8'h96, 11, 45, 8'h3C, 1'b1, line, busy_cyc, done_at, dones, glitches);
        tests_run++;
        if (line !== 16'({1'b1, 1'b0, 8'h96, 1'b0})) begin tests_failed++; $display("FAIL ignore_busy_line: got %h want %h", line, 16'({1'b1, 1'b0, 8'h96, 1'b0})); end
        tests_run++;
        if (dones !== 1 || glitches !== 0) begin tests_failed++; $display("FAIL ignore_busy_single: got dones=%0d glitches=%0d want 1/0", dones, glitches); end
        tests_run++;
        if (busy_v[0] !== 1'b0) begin tests_failed++; $display("FAIL ignore_busy_idle: got busy=%b want 0", busy_v[0]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] line;
        int busy_cyc, done_at, dones, glitches, bad;
        @(negedge sys_clk);
        tx_data    = 8'hA5;
        valid_v[0] = 1'b1;
        @(posedge sys_clk);
        #1;
        valid_v[0] = 1'b0;
        repeat (44) @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        tests_run++;
        if (out_v[0] !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_out: got %b want 1", out_v[0]); end
        tests_run++;
        if (busy_v[0] !== 1'b0 || ready_v[0] !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy_ready: got %b/%b want 0/0", busy_v[0], ready_v[0]); end
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            if (c == 2) sys_rst = 1'b0;
            if (done_v[0] !== 1'b0 || out_v[0] !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL rst_mid_quiet: got %0d bad cycles want 0", bad); end
        send_frame(0, 8'h55, 11, -1, 8'h00, 1'b0, line, busy_cyc, done_at, dones, glitches);
        tests_run++;
        if (line !== 16'({1'b1, 1'b0, 8'h55, 1'b0})) begin tests_failed++; $display("FAIL rst_mid_next_line: got %h want %h", line, 16'({1'b1, 1'b0, 8'h55, 1'b0})); end
        tests_run++;
        if (busy_cyc !== 110 || dones !== 1 || glitches !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_next_frame: got busy=%0d dones=%0d glitches=%0d want 110/1/0", busy_cyc, dones, glitches);
        end
    endtask

    initial begin
        test_reset();
        test_frame_8e1();
        test_odd_parity();
        test_7n2_data_change();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
